// File: rtl/maes_32bits_ks_ctrl_if.sv
// Handshake and control-strobe bundle between the masked AES control sequencer
// and the datapath/host around it. The sequencer side uses the master modport.
interface maes_32bits_ks_ctrl_if;
  logic [1:0] key_size;
  logic       valid_in;
  logic       in_ready;
  logic       cipher_valid;
  logic       out_ready;
  logic       busy;
  logic       global_init;
  logic       state_init;
  logic       kh_init;
  logic       rcon_rst;
  logic       state_enable;
  logic       state_en_MC;
  logic       enable_key_add;
  logic       kh_enable;
  logic       sbox_valid_in;
  logic       feed_sb_key;
  logic       rnd_req;
  logic       kh_sub_capture;
  logic [1:0] kh_sub_pos;
  logic       kh_rot;
  logic       rcon_update;
  logic       round_last;

  modport master (
    input  key_size, valid_in, out_ready,
    output in_ready, cipher_valid, busy, global_init, state_init, kh_init,
           rcon_rst, state_enable, state_en_MC, enable_key_add, kh_enable,
           sbox_valid_in, feed_sb_key, rnd_req, kh_sub_capture, kh_sub_pos,
           kh_rot, rcon_update, round_last
  );

  modport slave (
    output key_size, valid_in, out_ready,
    input  in_ready, cipher_valid, busy, global_init, state_init, kh_init,
           rcon_rst, state_enable, state_en_MC, enable_key_add, kh_enable,
           sbox_valid_in, feed_sb_key, rnd_req, kh_sub_capture, kh_sub_pos,
           kh_rot, rcon_update, round_last
  );
endinterface

// File: rtl/maes_32bits_ks_ctrl.sv
// Control sequencer for a 32-bit masked AES-128/192/256 core. Issues column and
// one-round-ahead key-schedule SubWord requests into an SBOX_LAT-deep Sbox pipe.
module maes_32bits_ks_ctrl #(
  parameter int SBOX_LAT          = 2,
  parameter bit SUPPORT_WIDE_KEYS = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  maes_32bits_ks_ctrl_if.master        bus
);
  localparam int S_LAST = SBOX_LAT + 4;
  localparam int STEP_W = $clog2(S_LAST + 1);

  typedef enum logic [1:0] {IDLE, PREKEY, ROUND, DONE} state_t;

  state_t            state_reg;
  logic [STEP_W-1:0] step_reg;
  logic [3:0]        rnd_reg;
  logic [3:0]        kw_reg;    // (4*(rnd+1)) mod Nk: first key word of the next round
  logic [1:0]        ksel_reg;  // 0:AES-128 1:AES-192 2:AES-256

  logic [1:0] ksel_in;
  logic [3:0] nk, nr, kw_sum, kw_next;
  logic       in_ready_w, accept, last_round;
  logic       sub_hit, sub_rot;
  logic [1:0] sub_pos;
  logic       col_issue, key_issue, sub_capture, st_window;

  assign ksel_in = (SUPPORT_WIDE_KEYS && bus.key_size != 2'b11) ? bus.key_size : 2'b00;

  assign nk         = 4'd4 + {1'b0, ksel_reg, 1'b0};
  assign nr         = 4'd10 + {1'b0, ksel_reg, 1'b0};
  assign kw_sum     = kw_reg + 4'd4;
  assign kw_next    = (kw_sum >= nk) ? kw_sum - nk : kw_sum;
  assign last_round = (rnd_reg == nr);

  // Which word of the next round (if any) needs SubWord, derived from kw alone.
  always_comb begin
    sub_hit = 1'b0;
    sub_pos = 2'd0;
    sub_rot = 1'b1;
    case (ksel_reg)
      2'd0: sub_hit = 1'b1;
      2'd1: begin
        sub_hit = (kw_reg == 4'd0) || (kw_reg == 4'd4);
        sub_pos = (kw_reg == 4'd4) ? 2'd2 : 2'd0;
      end
      default: begin
        // word 4 of an AES-256 schedule is not a SubWord word, only 12, 20, ...
        sub_hit = (kw_reg == 4'd0) || (state_reg == ROUND);
        sub_rot = (kw_reg == 4'd0);
      end
    endcase
  end

  assign in_ready_w = !rst && (state_reg == IDLE || state_reg == DONE);
  assign accept     = bus.valid_in && in_ready_w;

  assign col_issue   = !rst && state_reg == ROUND && step_reg <= STEP_W'(3);
  assign key_issue   = !rst && sub_hit &&
                       ((state_reg == PREKEY && step_reg == '0) ||
                        (state_reg == ROUND && !last_round && step_reg == STEP_W'(4)));
  assign sub_capture = !rst && sub_hit &&
                       ((state_reg == PREKEY && step_reg == STEP_W'(SBOX_LAT)) ||
                        (state_reg == ROUND && !last_round && step_reg == STEP_W'(S_LAST)));
  assign st_window   = !rst && state_reg == ROUND &&
                       step_reg >= STEP_W'(SBOX_LAT) && step_reg <= STEP_W'(SBOX_LAT + 3);

  assign bus.in_ready       = in_ready_w;
  assign bus.cipher_valid   = !rst && state_reg == DONE;
  assign bus.busy           = !rst && (state_reg == PREKEY || state_reg == ROUND);
  assign bus.global_init    = accept;
  assign bus.state_init     = accept;
  assign bus.kh_init        = accept;
  assign bus.rcon_rst       = accept;
  assign bus.state_enable   = accept || st_window;
  assign bus.state_en_MC    = st_window && !last_round;
  assign bus.enable_key_add = st_window;
  assign bus.kh_enable      = accept || st_window;
  assign bus.sbox_valid_in  = col_issue || key_issue;
  assign bus.feed_sb_key    = key_issue && !col_issue;
  assign bus.rnd_req        = col_issue || key_issue;
  assign bus.kh_sub_capture = sub_capture;
  assign bus.kh_sub_pos     = (key_issue || sub_capture) ? sub_pos : 2'd0;
  assign bus.kh_rot         = (key_issue || sub_capture) && sub_rot;
  assign bus.rcon_update    = sub_capture && sub_rot;
  assign bus.round_last     = !rst && state_reg == ROUND && last_round;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      rnd_reg   <= '0;
      kw_reg    <= '0;
      ksel_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            state_reg <= PREKEY;
            step_reg  <= '0;
            rnd_reg   <= '0;
            ksel_reg  <= ksel_in;
            kw_reg    <= (ksel_in == 2'd0) ? 4'd0 : 4'd4;
          end else if (state_reg == DONE && bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        PREKEY: begin
          if (step_reg == STEP_W'(SBOX_LAT)) begin
            state_reg <= ROUND;
            step_reg  <= '0;
            rnd_reg   <= 4'd1;
            kw_reg    <= kw_next;
          end else begin
            step_reg <= step_reg + 1'b1;
          end
        end
        ROUND: begin
          if (step_reg == STEP_W'(S_LAST)) begin
            step_reg <= '0;
            if (last_round) begin
              state_reg <= DONE;
            end else begin
              rnd_reg <= rnd_reg + 4'd1;
              kw_reg  <= kw_next;
            end
          end else begin
            step_reg <= step_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maes_32bits_ks_ctrl.sv
// Randomized bench for maes_32bits_ks_ctrl: three instances (SBOX_LAT=2, SBOX_LAT=4,
// AES-128 only) compared cycle by cycle against a word-level key-schedule model.
module tb_maes_32bits_ks_ctrl;
  localparam int B_BUSY = 19, B_CV = 18, B_IR = 17, B_GI = 16, B_SI = 15, B_KI = 14;
  localparam int B_RR = 13, B_SE = 12, B_MC = 11, B_EKA = 10, B_KHE = 9, B_SBV = 8;
  localparam int B_FEEDK = 7, B_RREQ = 6, B_CAPT = 5, B_POS_HI = 4, B_POS_LO = 3;
  localparam int B_ROT = 2, B_RCON = 1, B_LAST = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d       [3];
  logic        valid_in_d  [3];
  logic [1:0]  key_size_d  [3];
  logic        out_ready_d [3];
  logic [19:0] obs_vec     [3];

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    maes_32bits_ks_ctrl_if bus ();
    assign bus.valid_in  = valid_in_d[gi];
    assign bus.key_size  = key_size_d[gi];
    assign bus.out_ready = out_ready_d[gi];
    assign obs_vec[gi] = {bus.busy, bus.cipher_valid, bus.in_ready, bus.global_init,
                          bus.state_init, bus.kh_init, bus.rcon_rst, bus.state_enable,
                          bus.state_en_MC, bus.enable_key_add, bus.kh_enable,
                          bus.sbox_valid_in, bus.feed_sb_key, bus.rnd_req,
                          bus.kh_sub_capture, bus.kh_sub_pos, bus.kh_rot,
                          bus.rcon_update, bus.round_last};
    maes_32bits_ks_ctrl #(
      .SBOX_LAT          (gi == 1 ? 4 : 2),
      .SUPPORT_WIDE_KEYS (gi != 2)
    ) u_dut (
      .clk (clk),
      .rst (rst_d[gi]),
      .bus (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t observed=0x%05h expected=0x%05h", tag, $time, obs, exp);
    end
  endtask

  // Word i of the expanded key needs SubWord when i>=Nk and i%Nk==0 (with RotWord),
  // or Nk==8 and i%8==4 (plain). Search round r+1's four words.
  function automatic bit lookahead(input int nk, input int r, output int pos, output bit rot);
    pos = 0;
    rot = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = 4 * (r + 1) + k;
      if (i >= nk && (i % nk == 0 || (nk == 8 && i % 8 == 4))) begin
        pos = k;
        rot = (i % nk == 0);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Expected output vector c cycles after the accept cycle.
  function automatic logic [19:0] model_vec(input int lat, input int nk, input int c);
    int nr, s, tot, r, st, pos;
    bit rot, ok;
    logic [19:0] v;
    nr = nk + 6;
    s = lat + 5;
    tot = 2 + lat + nr * s;
    v = '0;
    pos = 0;
    rot = 1'b0;
    if (c >= tot) begin
      v[B_CV] = 1'b1;
      v[B_IR] = 1'b1;
      return v;
    end
    v[B_BUSY] = 1'b1;
    if (c <= lat + 1) begin
      r = 0;
      st = c - 1;
    end else begin
      r = (c - lat - 2) / s + 1;
      st = (c - lat - 2) % s;
    end
    ok = (r < nr) && lookahead(nk, r, pos, rot);
    if (r > 0) begin
      v[B_LAST] = (r == nr);
      if (st <= 3) begin
        v[B_SBV] = 1'b1;
        v[B_RREQ] = 1'b1;
      end
      if (st >= lat && st <= lat + 3) begin
        v[B_SE] = 1'b1;
        v[B_MC] = (r != nr);
        v[B_EKA] = 1'b1;
        v[B_KHE] = 1'b1;
      end
    end
    if (ok && ((r == 0 && st == 0) || (r > 0 && st == 4))) begin
      v[B_SBV] = 1'b1;
      v[B_FEEDK] = 1'b1;
      v[B_RREQ] = 1'b1;
      v[B_POS_HI:B_POS_LO] = 2'(pos);
      v[B_ROT] = rot;
    end
    if (ok && ((r == 0 && st == lat) || (r > 0 && st == lat + 4))) begin
      v[B_CAPT] = 1'b1;
      v[B_POS_HI:B_POS_LO] = 2'(pos);
      v[B_ROT] = rot;
      v[B_RCON] = rot;
    end
    return v;
  endfunction

  function automatic logic [19:0] acc_vec(input bit from_done);
    logic [19:0] v;
    v = '0;
    v[B_IR] = 1'b1; v[B_GI] = 1'b1; v[B_SI] = 1'b1; v[B_KI] = 1'b1;
    v[B_RR] = 1'b1; v[B_SE] = 1'b1; v[B_KHE] = 1'b1;
    v[B_CV] = from_done;
    return v;
  endfunction

  function automatic logic [19:0] idle_vec(input bit done);
    logic [19:0] v;
    v = '0;
    v[B_IR] = 1'b1;
    v[B_CV] = done;
    return v;
  endfunction

  task automatic run_dut(input int d, input int nblocks, input bit do_abort);
    int lat, nk, nr, tot, abort_c, hold, rcon_obs, se_obs, rcon_exp, pos;
    bit from_done, aborted, wide, go_idle, rot;
    logic [1:0] ks;
    logic [19:0] e, o;
    lat = (d == 1) ? 4 : 2;
    wide = (d != 2);
    from_done = 1'b0;
    for (int b = 0; b < nblocks; b++) begin
      ks = (b < 3) ? 2'(b) : 2'($urandom_range(0, 3));
      if (do_abort && b == 3) ks = 2'd0;
      nk = (wide && ks == 2'd1) ? 6 : (wide && ks == 2'd2) ? 8 : 4;
      nr = nk + 6;
      tot = 2 + lat + nr * (lat + 5);
      abort_c = (do_abort && b == 3) ? lat + 2 + 4 * (lat + 5) + 3 : -1;
      $display("block dut=%0d ks=%0d nk=%0d sbox_lat=%0d latency=%0d from_done=%0d abort=%0d",
               d, ks, nk, lat, tot, from_done, abort_c >= 0);
      @(negedge clk);
      valid_in_d[d] = 1'b1;
      key_size_d[d] = ks;
      out_ready_d[d] = 1'($urandom);
      #1;
      check($sformatf("d%0d accept", d), 32'(obs_vec[d]), 32'(acc_vec(from_done)));
      aborted = 1'b0;
      rcon_obs = 0;
      se_obs = 0;
      for (int c = 1; c < tot && !aborted; c++) begin
        @(negedge clk);
        valid_in_d[d] = 1'($urandom);
        key_size_d[d] = 2'($urandom);
        out_ready_d[d] = 1'($urandom);
        if (c == abort_c) begin
          rst_d[d] = 1'b1;
          #1;
          check($sformatf("d%0d rst_mid", d), 32'(obs_vec[d]), 32'd0);
          @(negedge clk);
          rst_d[d] = 1'b0;
          valid_in_d[d] = 1'b0;
          #1;
          check($sformatf("d%0d rst_idle", d), 32'(obs_vec[d]), 32'(idle_vec(1'b0)));
          aborted = 1'b1;
          from_done = 1'b0;
        end else begin
          #1;
          e = model_vec(lat, nk, c);
          o = obs_vec[d];
          if (!(e[B_FEEDK] || e[B_CAPT])) begin
            o[B_POS_HI:B_POS_LO] = 2'b00;
            o[B_ROT] = 1'b0;
          end
          rcon_obs += int'(o[B_RCON]);
          se_obs += int'(o[B_SE]);
          check($sformatf("d%0d ks%0d c%0d", d, ks, c), 32'(o), 32'(e));
        end
      end
      if (!aborted) begin
        rcon_exp = 0;
        for (int r = 0; r < nr; r++)
          if (lookahead(nk, r, pos, rot) && rot) rcon_exp++;
        check($sformatf("d%0d rcon_count", d), 32'(rcon_obs), 32'(rcon_exp));
        check($sformatf("d%0d state_en_count", d), 32'(se_obs), 32'(4 * nr));
        hold = (b == 0) ? 5 : $urandom_range(0, 5);
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          valid_in_d[d] = 1'b0;
          out_ready_d[d] = 1'b0;
          #1;
          check($sformatf("d%0d done_hold", d), 32'(obs_vec[d]), 32'(idle_vec(1'b1)));
        end
        go_idle = (b == 0) ? 1'b1 : (b == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (go_idle) begin
          @(negedge clk);
          valid_in_d[d] = 1'b0;
          out_ready_d[d] = 1'b1;
          #1;
          check($sformatf("d%0d done_release", d), 32'(obs_vec[d]), 32'(idle_vec(1'b1)));
          @(negedge clk);
          out_ready_d[d] = 1'b0;
          #1;
          check($sformatf("d%0d idle", d), 32'(obs_vec[d]), 32'(idle_vec(1'b0)));
          from_done = 1'b0;
        end else begin
          from_done = 1'b1;
        end
      end
    end
    @(negedge clk);
    valid_in_d[d] = 1'b0;
    out_ready_d[d] = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_d[d] = 1'b1;
      valid_in_d[d] = 1'b0;
      key_size_d[d] = 2'd0;
      out_ready_d[d] = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++)
        check($sformatf("d%0d rst_hold", d), 32'(obs_vec[d]), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_d[d] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d post_rst", d), 32'(obs_vec[d]), 32'(idle_vec(1'b0)));
    run_dut(0, 8, 1'b1);
    run_dut(1, 4, 1'b0);
    run_dut(2, 3, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
